// File: rtl/img_mem_pkg.sv
// Shared image-memory definitions used by the display, processing and arbiter blocks.
// Geometry, pixel format and the owner tag that routes read responses.
package img_mem_pkg;

  localparam int IMG_W     = 320;
  localparam int IMG_H     = 240;
  localparam int IMG_DEPTH = IMG_W * IMG_H;
  localparam int PIX_W     = 12;
  localparam int ADDR_W    = $clog2(IMG_DEPTH);

  typedef enum logic {
    OWN_D = 1'b0,
    OWN_P = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
    logic   oob;
  } rd_tag_t;

endpackage

// File: rtl/image_bram_arbiter_if.sv
// Request/response and BRAM-side signals of the image BRAM arbiter.
// slave = arbiter view, master = requesters plus BRAM view.
interface image_bram_arbiter_if #(
  parameter int ADDR_W = img_mem_pkg::ADDR_W,
  parameter int DATA_W = img_mem_pkg::PIX_W
);

  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic              d_gnt;
  logic              d_rsp_valid;
  logic [DATA_W-1:0] d_rsp_data;

  logic              p_req;
  logic              p_we;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] p_wdata;
  logic              p_gnt;
  logic              p_rsp_valid;
  logic [DATA_W-1:0] p_rsp_data;

  logic [ADDR_W-1:0] bram_addr;
  logic              bram_we;
  logic [DATA_W-1:0] bram_wdata;
  logic [DATA_W-1:0] bram_rdata;

  modport slave (
    input  d_req, d_addr,
    output d_gnt, d_rsp_valid, d_rsp_data,
    input  p_req, p_we, p_addr, p_wdata,
    output p_gnt, p_rsp_valid, p_rsp_data,
    output bram_addr, bram_we, bram_wdata,
    input  bram_rdata
  );

  modport master (
    output d_req, d_addr,
    input  d_gnt, d_rsp_valid, d_rsp_data,
    output p_req, p_we, p_addr, p_wdata,
    input  p_gnt, p_rsp_valid, p_rsp_data,
    input  bram_addr, bram_we, bram_wdata,
    output bram_rdata
  );

endinterface

// File: rtl/img_rd_tag_pipe.sv
// Two-stage read tag pipeline aligned with the BRAM's registered read;
// steers the returning pixel to the port that issued the read.
module img_rd_tag_pipe import img_mem_pkg::*; #(
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iss_rd_i,
  input  owner_e            iss_owner_i,
  input  logic              iss_oob_i,
  input  logic [DATA_W-1:0] bram_rdata_i,
  output logic              d_rsp_valid_o,
  output logic [DATA_W-1:0] d_rsp_data_o,
  output logic              p_rsp_valid_o,
  output logic [DATA_W-1:0] p_rsp_data_o
);

  rd_tag_t           stage1_q, stage1_d;
  rd_tag_t           stage2_q, stage2_d;
  logic [DATA_W-1:0] rsp_data;

  always_comb begin
    stage1_d       = '0;
    stage1_d.valid = iss_rd_i;
    stage1_d.owner = iss_owner_i;
    stage1_d.oob   = iss_oob_i;
    stage2_d       = stage1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage1_q <= '0;
      stage2_q <= '0;
    end else begin
      stage1_q <= stage1_d;
      stage2_q <= stage2_d;
    end
  end

  // Out-of-range reads never touched real memory, so their data is forced to zero.
  always_comb begin
    rsp_data      = stage2_q.oob ? '0 : bram_rdata_i;
    d_rsp_valid_o = stage2_q.valid && (stage2_q.owner == OWN_D);
    p_rsp_valid_o = stage2_q.valid && (stage2_q.owner == OWN_P);
    d_rsp_data_o  = d_rsp_valid_o ? rsp_data : '0;
    p_rsp_data_o  = p_rsp_valid_o ? rsp_data : '0;
  end

endmodule

// File: rtl/image_bram_arbiter.sv
// Single-port image BRAM shared between display fetch (D, priority) and the
// processing engine (P), with a starvation guard that forces periodic P grants.
module image_bram_arbiter #(
  parameter int ADDR_W       = 17,
  parameter int DATA_W       = 12,
  parameter int DEPTH        = 76800,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  image_bram_arbiter_if.slave  arb,
  output logic                 err_oob_o
);

  import img_mem_pkg::*;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic              run_q;
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
  logic              bram_we_q, bram_we_d;
  logic [DATA_W-1:0] bram_wdata_q, bram_wdata_d;
  logic              err_oob_q, err_oob_d;

  logic              d_gnt, p_gnt, starved, issue;
  logic [ADDR_W-1:0] iss_addr;
  logic              iss_oob, iss_rd;
  owner_e            iss_owner;

  // run_q keeps both grants low until the first clock after reset release.
  always_comb begin
    starved = (starve_cnt_q == LIMIT);
    d_gnt   = 1'b0;
    p_gnt   = 1'b0;
    if (run_q) begin
      if (arb.d_req && !(arb.p_req && starved)) begin
        d_gnt = 1'b1;
      end else if (arb.p_req) begin
        p_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    issue     = d_gnt || p_gnt;
    iss_addr  = p_gnt ? arb.p_addr : arb.d_addr;
    iss_oob   = (32'(iss_addr) >= 32'(DEPTH));
    iss_rd    = issue && !(p_gnt && arb.p_we);
    iss_owner = p_gnt ? OWN_P : OWN_D;
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!run_q || !arb.p_req || p_gnt) begin
      starve_cnt_d = '0;
    end else if (!starved) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end

    bram_addr_d  = bram_addr_q;
    bram_wdata_d = bram_wdata_q;
    bram_we_d    = 1'b0;
    err_oob_d    = err_oob_q;
    if (issue) begin
      bram_addr_d = iss_addr;
      if (iss_oob) begin
        err_oob_d = 1'b1;
      end
      if (p_gnt && arb.p_we) begin
        bram_wdata_d = arb.p_wdata;
        bram_we_d    = !iss_oob;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q        <= 1'b0;
      starve_cnt_q <= '0;
      bram_addr_q  <= '0;
      bram_we_q    <= 1'b0;
      bram_wdata_q <= '0;
      err_oob_q    <= 1'b0;
    end else begin
      run_q        <= 1'b1;
      starve_cnt_q <= starve_cnt_d;
      bram_addr_q  <= bram_addr_d;
      bram_we_q    <= bram_we_d;
      bram_wdata_q <= bram_wdata_d;
      err_oob_q    <= err_oob_d;
    end
  end

  logic              d_rsp_valid, p_rsp_valid;
  logic [DATA_W-1:0] d_rsp_data, p_rsp_data;

  img_rd_tag_pipe #(
    .DATA_W (DATA_W)
  ) u_tag_pipe (
    .clk           (clk),
    .rst_n         (rst_n),
    .iss_rd_i      (iss_rd),
    .iss_owner_i   (iss_owner),
    .iss_oob_i     (iss_oob),
    .bram_rdata_i  (arb.bram_rdata),
    .d_rsp_valid_o (d_rsp_valid),
    .d_rsp_data_o  (d_rsp_data),
    .p_rsp_valid_o (p_rsp_valid),
    .p_rsp_data_o  (p_rsp_data)
  );

  assign arb.d_gnt       = d_gnt;
  assign arb.p_gnt       = p_gnt;
  assign arb.d_rsp_valid = d_rsp_valid;
  assign arb.d_rsp_data  = d_rsp_data;
  assign arb.p_rsp_valid = p_rsp_valid;
  assign arb.p_rsp_data  = p_rsp_data;
  assign arb.bram_addr   = bram_addr_q;
  assign arb.bram_we     = bram_we_q;
  assign arb.bram_wdata  = bram_wdata_q;
  assign err_oob_o       = err_oob_q;

endmodule

// File: tb/tb_image_bram_arbiter.sv
// Directed bench for image_bram_arbiter: stimulus pushes expected read data into
// a queue, a negedge monitor pops and compares each response as it appears.
module tb_image_bram_arbiter;

  localparam int DEPTH = 76800;

  typedef struct {
    bit          is_p;
    logic [11:0] data;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err_oob;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  logic [11:0] mem [0:DEPTH-1];

  image_bram_arbiter_if #(.ADDR_W(17), .DATA_W(12)) bus ();

  image_bram_arbiter #(
    .ADDR_W       (17),
    .DATA_W       (12),
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .arb       (bus),
    .err_oob_o (err_oob)
  );

  always #5 clk = ~clk;

  // Read-first single-port BRAM with a registered read.
  always @(posedge clk) begin
    if (bus.bram_we) mem[bus.bram_addr] <= bus.bram_wdata;
    bus.bram_rdata <= (32'(bus.bram_addr) < DEPTH) ? mem[bus.bram_addr] : 12'h000;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && (bus.d_rsp_valid || bus.p_rsp_valid)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", {30'd0, bus.d_rsp_valid, bus.p_rsp_valid}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.name, "_owner"}, {30'd0, bus.d_rsp_valid, bus.p_rsp_valid},
            e.is_p ? 32'd1 : 32'd2);
        chk({e.name, "_data"}, e.is_p ? bus.p_rsp_data : bus.d_rsp_data, e.data);
      end
    end
  end

  task automatic issue(input bit is_p, input bit we, input logic [16:0] a,
                       input logic [11:0] wd, input bit push, input logic [11:0] expd,
                       input string name);
    int   n;
    logic g;
    @(negedge clk);
    bus.d_req = !is_p;
    bus.p_req = is_p;
    if (is_p) begin
      bus.p_addr  = a;
      bus.p_we    = we;
      bus.p_wdata = wd;
    end else begin
      bus.d_addr = a;
    end
    #1;
    n = 0;
    g = is_p ? bus.p_gnt : bus.d_gnt;
    while (!g && n < 16) begin
      @(negedge clk); #1;
      n++;
      g = is_p ? bus.p_gnt : bus.d_gnt;
    end
    chk({name, "_gnt"}, {31'd0, g}, 32'd1);
    chk({name, "_other_gnt"}, {31'd0, is_p ? bus.d_gnt : bus.p_gnt}, 32'd0);
    if (g && push) exp_q.push_back('{is_p, expd, name});
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    bus.d_req = 1'b0;
    bus.p_req = 1'b0;
    bus.p_we  = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 12'((i * 7 + 3) & 32'hFFF);
    bus.d_req = 0; bus.d_addr = 0;
    bus.p_req = 0; bus.p_we = 0; bus.p_addr = 0; bus.p_wdata = 0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_bram_we", {31'd0, bus.bram_we}, 0);
    chk("rst_bram_addr", {15'd0, bus.bram_addr}, 0);
    chk("rst_err_oob", {31'd0, err_oob}, 0);
    chk("rst_rsp_valid", {30'd0, bus.d_rsp_valid, bus.p_rsp_valid}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // D-only consecutive reads including the last legal address
    issue(0, 0, 17'd0,     0, 1, 12'h003, "d_rd0");
    issue(0, 0, 17'd1,     0, 1, 12'h00A, "d_rd1");
    issue(0, 0, 17'd2,     0, 1, 12'h011, "d_rd2");
    issue(0, 0, 17'd76799, 0, 1, 12'h3FC, "d_rd_last");
    idle(5);
    chk("legal_last_no_err", {31'd0, err_oob}, 0);

    // Starvation: both ports held, expect 8 D grants then 1 P grant, repeating
    for (int i = 0; i < 27; i++) begin
      bit exp_p;
      @(negedge clk);
      bus.d_req = 1; bus.d_addr = 17'd10;
      bus.p_req = 1; bus.p_we = 0; bus.p_addr = 17'd20;
      #1;
      exp_p = ((i % 9) == 8);
      chk($sformatf("starve_gnt_%0d", i), {30'd0, bus.d_gnt, bus.p_gnt},
          exp_p ? 32'd1 : 32'd2);
      if (bus.p_gnt) exp_q.push_back('{1'b1, 12'h08F, "starve_p"});
      else if (bus.d_gnt) exp_q.push_back('{1'b0, 12'h049, "starve_d"});
    end
    idle(5);

    // P write followed immediately by a P read of the same address
    issue(1, 1, 17'd100, 12'hABC, 0, 0, "p_wr");
    @(negedge clk);
    bus.p_we = 0; bus.p_addr = 17'd100;
    #1;
    chk("wr_bram_we", {31'd0, bus.bram_we}, 1);
    chk("wr_bram_addr", {15'd0, bus.bram_addr}, 100);
    chk("wr_bram_wdata", {20'd0, bus.bram_wdata}, 32'hABC);
    chk("rd_after_wr_gnt", {31'd0, bus.p_gnt}, 1);
    if (bus.p_gnt) exp_q.push_back('{1'b1, 12'hABC, "p_rd_after_wr"});
    @(negedge clk);
    bus.p_req = 0;
    #1;
    chk("wr_we_pulse_end", {31'd0, bus.bram_we}, 0);
    idle(4);

    // Out-of-range write then read
    issue(1, 1, 17'd76800, 12'h555, 0, 0, "oob_wr");
    @(negedge clk);
    bus.p_req = 0; bus.p_we = 0;
    #1;
    chk("oob_wr_dropped", {31'd0, bus.bram_we}, 0);
    chk("oob_err_set", {31'd0, err_oob}, 1);
    issue(0, 0, 17'd76805, 0, 1, 12'h000, "oob_rd");
    idle(5);
    chk("oob_err_sticky", {31'd0, err_oob}, 1);

    // Reset while a D read is in flight
    issue(0, 0, 17'd7, 0, 0, 0, "rst_rd");
    @(negedge clk);
    rst_n = 1'b0;
    bus.d_req = 1; bus.d_addr = 17'd7;
    #1;
    chk("inrst_d_gnt", {31'd0, bus.d_gnt}, 0);
    chk("inrst_rsp_valid", {30'd0, bus.d_rsp_valid, bus.p_rsp_valid}, 0);
    chk("inrst_bram_we", {31'd0, bus.bram_we}, 0);
    chk("inrst_bram_addr", {15'd0, bus.bram_addr}, 0);
    chk("inrst_err_oob", {31'd0, err_oob}, 0);
    @(negedge clk);
    #1;
    chk("inrst_rsp_valid2", {30'd0, bus.d_rsp_valid, bus.p_rsp_valid}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.d_req = 0;
    idle(4);
    issue(0, 0, 17'd7, 0, 1, 12'h034, "post_rst_rd");
    idle(5);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
